// File: rtl/bcd_serial_addsub_if.sv
// rtl/bcd_serial_addsub_if.sv - start/done handshake and operand/result bundle for bcd_serial_addsub
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic                  cin;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;
    logic                  busy;
    logic                  done;

    modport master (
        output start, sub, cin, a, b,
        input  sum, cout, err, busy, done
    );

    modport slave (
        input  start, sub, cin, a, b,
        output sum, cout, err, busy, done
    );
endinterface

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor, LSD first
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_serial_addsub_if.slave bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    // Operand copies shift right one digit per RUN cycle, so the live digit is always [3:0].
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_sub;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic [IDX_W-1:0]   r_idx;

    logic               w_accept;
    logic               w_bad;
    logic               w_last;
    logic [3:0]         w_b_eff;
    logic [4:0]         w_t;
    logic [4:0]         w_tc;
    logic               w_carry_out;
    logic [3:0]         w_sum_dig;

    assign w_last = (r_idx == IDX_W'(DIGITS - 1));

    // Flag any non-decimal nibble in either incoming operand.
    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if ((bus.a[4*k +: 4] > 4'd9) || (bus.b[4*k +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    // Single digit slice: nines-complement B in sub mode, binary add, +6 decimal correction.
    always_comb begin
        w_b_eff     = r_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
        w_t         = {1'b0, r_a[3:0]} + {1'b0, w_b_eff} + {4'b0, r_carry};
        w_tc        = w_t;
        w_carry_out = 1'b0;
        if (w_t > 5'd9) begin
            w_tc        = w_t + 5'd6;
            w_carry_out = w_tc[4];
        end
        w_sum_dig   = w_tc[3:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; start is only looked at in IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = w_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then write one result digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_sub <= bus.sub;
            r_sum <= '0;
            r_idx <= '0;
            if (w_bad) begin
                r_err  <= 1'b1;
                r_cout <= 1'b0;
            end else begin
                r_err   <= 1'b0;
                r_carry <= bus.sub ? ~bus.cin : bus.cin;
            end
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_sum[4*k +: 4] <= w_sum_dig;
                end
            end
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_carry_out;
            if (w_last) begin
                r_cout <= w_carry_out;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - scoreboard bench for bcd_serial_addsub
module tb_bcd_serial_addsub;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t q[$];

    bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int           x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        bit r = 1'b0;
        for (int k = 0; k < DIGITS; k++) if (v[4*k +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c);
        exp_t e;
        int   m = 10 ** DIGITS;
        int   r;
        if (has_bad(a) || has_bad(b)) begin
            e.sum = '0; e.cout = 1'b0; e.err = 1'b1;
        end else if (!s) begin
            r = bcd2int(a) + bcd2int(b) + int'(c);
            e.sum = int2bcd(r % m); e.cout = (r >= m); e.err = 1'b0;
        end else begin
            r = bcd2int(a) - bcd2int(b) - int'(c);
            e.err = 1'b0;
            if (r >= 0) begin
                e.sum = int2bcd(r); e.cout = 1'b1;
            end else begin
                e.sum = int2bcd(m + r); e.cout = 1'b0;
            end
        end
        return e;
    endfunction

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum",  64'(bus.sum),  64'(e.sum));
                check("cout", 64'(bus.cout), 64'(e.cout));
                check("err",  64'(bus.err),  64'(e.err));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c);
        exp_t e;
        int   n;
        e = model(a, b, s, c);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = ~s; bus.cin = ~c;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_first", 64'(bus.busy), 64'd1);
        end while (bus.done !== 1'b1 && n < 40);
        check("latency", 64'(n), e.err ? 64'd1 : 64'(DIGITS + 1));
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("hold_sum", 64'(bus.sum), 64'(e.sum));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_sum",  64'(bus.sum),  64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_err",  64'(bus.err),  64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;

        run_op(16'h1234, 16'h8766, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0000, 1'b0, 1'b1);
        run_op(16'h9999, 16'h9999, 1'b0, 1'b1);
        run_op(16'h5000, 16'h1234, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1);
        run_op(16'h1234, 16'h5000, 1'b1, 1'b0);
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
        run_op(16'h0100, 16'h000F, 1'b1, 1'b0);
        run_op(16'h4321, 16'h4321, 1'b1, 1'b0);

        // start held high through RUN and DONE with changing operands
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        q.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        bus.a = 16'h5555;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("hs_busy", 64'(bus.busy), 64'd1);
        end while (bus.done !== 1'b1 && n < 40);
        check("hs_latency", 64'(n), 64'(DIGITS + 1));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (DIGITS + 4) @(negedge clk);
        check("hs_queue_empty", 64'(q.size()), 64'd0);

        // reset in the 2nd RUN cycle discards the operation
        @(negedge clk);
        bus.a = 16'h0999; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_sum",  64'(bus.sum),  64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        repeat (DIGITS + 3) @(negedge clk);
        run_op(16'h0999, 16'h0001, 1'b0, 1'b0);

        // start and reset together: reset wins
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 64'(bus.busy), 64'd0);
        repeat (DIGITS + 3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            for (int k = 0; k < DIGITS; k++) begin
                ra[4*k +: 4] = 4'($urandom_range(0, 9));
                rb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("final_queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
